// File: rtl/param_burst_sequencer_pkg.sv
// Shared definitions for the burst sequencer.
// - Default widths and depth.
// - Sequencer state enum.
// - Address wrap-increment helper (wraps at DEPTH-1, not at 2**ADDR_WIDTH).
package param_burst_sequencer_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 16;
    localparam int unsigned DEF_ADDR_WIDTH     = 12;
    localparam int unsigned DEF_DEPTH          = 512;
    localparam int unsigned DEF_LEN_WIDTH      = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

    // Next address in a burst: legal range is 0..depth-1, so wrap at depth-1.
    function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input logic [31:0] depth);
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/param_burst_sequencer_addr_gen.sv
// Burst address / beat bookkeeping for the sequencer.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_load           latch a new burst (start address, beats-minus-one)
//   i_addr, i_len    burst start address and beat count minus one
//   i_advance        step to the next beat (address wraps at DEPTH-1)
//   o_addr           current beat address
//   o_last           current beat is the final one of the burst
module param_burst_addr_gen
    import param_burst_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_addr   <= i_addr;
            r_remain <= i_len;
        end else if (i_advance) begin
            r_addr   <= ADDR_WIDTH'(wrap_inc(32'(r_addr), 32'(DEPTH)));
            r_remain <= r_remain - LEN_WIDTH'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_remain == '0);

endmodule

// File: rtl/param_burst_sequencer.sv
// Command-driven burst sequencer in front of a memory-style access stage.
// Takes (start address, beats-minus-one) commands plus a host write-data
// stream, issues each beat downstream (addr/data_in, wait for ready),
// captures data_out and returns it as a valid/ready response stream with a
// last flag on the final beat.
// Ports:
//   i_clk, i_rst_n                         clock, async active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_addr,
//   i_cmd_len                              burst command
//   i_wr_valid/o_wr_ready, i_wr_data       host write beats
//   o_mem_addr, o_mem_data_in,
//   i_mem_data_out, i_mem_ready            downstream access stage
//   o_rsp_valid/i_rsp_ready, o_rsp_data,
//   o_rsp_last                             response stream
//   o_busy                                 not IDLE
//   o_err                                  one-cycle error pulse
// Optional feature macro: SEQ_TIMEOUT_EN -- bounds the ISSUE wait to
// TIMEOUT_CYCLES; on expiry pulses err, returns rsp_data=0 with rsp_last=1
// and drops the rest of the burst.
module param_burst_sequencer
    import param_burst_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter int unsigned LEN_WIDTH      = DEF_LEN_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data_in,
    input  logic [DATA_WIDTH-1:0] i_mem_data_out,
    input  logic                  i_mem_ready,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_last,
    output logic                  o_busy,
    output logic                  o_err
);

    seq_state_e r_state, w_next;

    logic                  r_rdy_en;   // keeps cmd_ready low until the first edge out of reset
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data_in;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_last;
    logic                  r_err;

    logic                  w_cmd_fire, w_addr_ok, w_wr_fire, w_mem_done, w_rsp_fire;
    logic                  w_timeout, w_load, w_advance, w_last;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_cmd_fire = i_cmd_valid && o_cmd_ready;
    assign w_addr_ok  = (32'(i_cmd_addr) < DEPTH);
    assign w_wr_fire  = (r_state == LOAD) && i_wr_valid;
    assign w_mem_done = (r_state == ISSUE) && i_mem_ready;
    assign w_rsp_fire = (r_state == RESP) && i_rsp_ready;
    assign w_load     = w_cmd_fire && w_addr_ok;
    assign w_advance  = w_rsp_fire && !r_rsp_last;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    // Counts ISSUE cycles without mem_ready; cleared whenever we leave ISSUE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_tmo_cnt <= '0;
        else if (r_state != ISSUE)
            r_tmo_cnt <= '0;
        else if (!i_mem_ready)
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end

    assign w_timeout = (r_state == ISSUE) && !i_mem_ready &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    param_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .DEPTH      (DEPTH)
    ) u_addr_gen (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (w_load),
        .i_addr    (i_cmd_addr),
        .i_len     (i_cmd_len),
        .i_advance (w_advance),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rdy_en <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_load)                       w_next = LOAD;
            LOAD:    if (i_wr_valid)                   w_next = ISSUE;
            ISSUE:   if (w_mem_done || w_timeout)      w_next = RESP;
            RESP:    if (i_rsp_ready)                  w_next = r_rsp_last ? IDLE : LOAD;
            default:                                   w_next = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_cmd_ready = 1'b0;
        o_wr_ready  = 1'b0;
        o_rsp_valid = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                o_cmd_ready = r_rdy_en;
                o_busy      = 1'b0;
            end
            LOAD:    o_wr_ready  = 1'b1;
            RESP:    o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Registered datapath: downstream request is held from LOAD exit until the
    // next LOAD; response is held from ISSUE exit through the RESP handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_rsp_data    <= '0;
            r_rsp_last    <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_err <= (w_cmd_fire && !w_addr_ok) || w_timeout;
            if (w_wr_fire) begin
                r_mem_addr    <= w_addr;
                r_mem_data_in <= i_wr_data;
            end
            if (w_mem_done) begin
                r_rsp_data <= i_mem_data_out;
                r_rsp_last <= w_last;
            end else if (w_timeout) begin
                r_rsp_data <= '0;
                r_rsp_last <= 1'b1;   // forces return to IDLE, dropping remaining beats
            end
        end
    end

    assign o_mem_addr    = r_mem_addr;
    assign o_mem_data_in = r_mem_data_in;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_last    = r_rsp_last;
    assign o_err         = r_err;

endmodule

// File: tb/tb_param_burst_sequencer.sv
module tb_param_burst_sequencer;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int DEPTH = 512;
    localparam int LW    = 8;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic          mem_ready;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0] rsp_data;
    logic          busy, err;

    int errors = 0;
    int checks = 0;

    // Observations from the burst driver
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    logic          obs_last[$];
    logic [DW-1:0] sent_data[$];
    int            unstable, wr_in_resp, stalls;

    always #5 clk = ~clk;

    // Downstream stage model: read-back word is a fixed scramble of addr and data_in
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return d ^ (DW'(a) * 16'd7 + 16'h5A3C);
    endfunction

    assign mem_data_out = memf(mem_addr, mem_data_in);

    param_burst_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
        .o_mem_addr(mem_addr), .o_mem_data_in(mem_data_in), .i_mem_data_out(mem_data_out),
        .i_mem_ready(mem_ready),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_last(rsp_last),
        .o_busy(busy), .o_err(err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs;
        obs_addr.delete(); obs_data.delete(); obs_last.delete(); sent_data.delete();
        unstable = 0; wr_in_resp = 0; stalls = 0;
    endtask

    // Drives one full burst with given downstream / response delays and records what it sees.
    task automatic run_burst(input logic [AW-1:0] a, input int len, input int mdly, input int rdly);
        int budget;
        logic [DW-1:0] d;
        logic l;
        budget = 0;
        while (!cmd_ready && budget < 50) begin tick; budget++; end
        if (!cmd_ready) begin stalls++; return; end
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = LW'(len);
        tick;
        cmd_valid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            d = DW'($urandom);
            wr_valid = 1'b1; wr_data = d; sent_data.push_back(d);
            mem_ready = 1'($urandom_range(0, 1));   // must be ignored in LOAD
            budget = 0;
            while (!wr_ready && budget < 50) begin tick; budget++; end
            if (!wr_ready) begin stalls++; wr_valid = 1'b0; mem_ready = 1'b0; return; end
            tick;
            wr_valid = 1'b0; mem_ready = 1'b0;
            obs_addr.push_back(mem_addr);
            for (int j = 0; j < mdly; j++) begin
                tick;
                if (mem_addr !== obs_addr[$] || rsp_valid !== 1'b0) unstable++;
            end
            mem_ready = 1'b1;
            tick;
            mem_ready = 1'b0;
            if (rsp_valid !== 1'b1) begin stalls++; return; end
            d = rsp_data; l = rsp_last;
            obs_data.push_back(d); obs_last.push_back(l);
            for (int j = 0; j < rdly; j++) begin
                tick;
                if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_last !== l) unstable++;
                if (wr_ready !== 1'b0) wr_in_resp++;
            end
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        cmd_valid = 0; cmd_addr = '0; cmd_len = '0; wr_valid = 0; wr_data = '0;
        mem_ready = 0; rsp_ready = 0;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({cmd_ready, wr_ready, mem_addr, mem_data_in, rsp_valid, rsp_data, rsp_last, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got cmd_rdy=%b wr_rdy=%b maddr=%h mdin=%h rv=%b rd=%h rl=%b busy=%b err=%b, want all 0",
                     cmd_ready, wr_ready, mem_addr, mem_data_in, rsp_valid, rsp_data, rsp_last, busy, err);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_release_cmd_ready: got %b want 0", cmd_ready); end
        tick;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL first_cycle_cmd_ready: got cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_single_beat;
        logic [DW-1:0] exp;
        exp = memf(12'h010, 16'hA5A5);
        cmd_valid = 1; cmd_addr = 12'h010; cmd_len = '0;
        wr_valid = 1; wr_data = 16'hA5A5; mem_ready = 1; rsp_ready = 1;
        tick;   // cycle 1
        cmd_valid = 0;
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_cycle1: got wr_ready=%b busy=%b cmd_ready=%b rsp_valid=%b want 1/1/0/0",
                               wr_ready, busy, cmd_ready, rsp_valid);
        end
        tick;   // cycle 2
        wr_valid = 0;
        checks++;
        if (mem_addr !== 12'h010 || mem_data_in !== 16'hA5A5 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_cycle2: got mem_addr=%h data_in=%h rsp_valid=%b want 010/a5a5/0",
                               mem_addr, mem_data_in, rsp_valid);
        end
        tick;   // cycle 3
        mem_ready = 0;
        // a new command offered during RESP must wait for IDLE
        cmd_valid = 1; cmd_addr = 12'd600; cmd_len = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_last !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL single_cycle3: got rsp_valid=%b data=%h last=%b cmd_ready=%b want 1/%h/1/0",
                               rsp_valid, rsp_data, rsp_last, cmd_ready, exp);
        end
        tick;   // cycle 4: back in IDLE, command not yet consumed
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL single_cycle4: got rsp_valid=%b cmd_ready=%b busy=%b err=%b want 0/1/0/0",
                               rsp_valid, cmd_ready, busy, err);
        end
        tick;   // cycle 5: pending bad command consumed with an error
        cmd_valid = 0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_pending_cmd: got err=%b busy=%b want 1/0", err, busy);
        end
        tick;
    endtask

    task automatic test_bad_addr;
        logic [AW-1:0] bad[3];
        bad[0] = 12'd600; bad[1] = 12'd512; bad[2] = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1; cmd_addr = bad[i]; cmd_len = LW'(2); wr_valid = 1;
            tick;
            cmd_valid = 0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++; $display("FAIL bad_addr_%0d: got err=%b busy=%b wr_ready=%b cmd_ready=%b want 1/0/0/1",
                                   bad[i], err, busy, wr_ready, cmd_ready);
            end
            tick;
            wr_valid = 0;
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0) begin
                errors++; $display("FAIL bad_addr_pulse_%0d: got err=%b busy=%b wr_ready=%b want 0/0/0",
                                   bad[i], err, busy, wr_ready);
            end
        end
    endtask

    task automatic test_wrap;
        logic [AW-1:0] ea[4];
        ea[0] = 12'd510; ea[1] = 12'd511; ea[2] = 12'd0; ea[3] = 12'd1;
        clear_obs();
        run_burst(12'd510, 3, 0, 0);
        checks++;
        if (stalls != 0 || obs_addr.size() != 4 || obs_data.size() != 4) begin
            errors++; $display("FAIL wrap_beats: got stalls=%0d beats=%0d want 0/4", stalls, obs_data.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_addr[k] !== ea[k] || obs_last[k] !== (k == 3) || obs_data[k] !== memf(ea[k], sent_data[k])) begin
                    errors++; $display("FAIL wrap_beat%0d: got addr=%0d last=%b data=%h want %0d/%b/%h",
                                       k, obs_addr[k], obs_last[k], obs_data[k], ea[k], (k == 3), memf(ea[k], sent_data[k]));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [AW-1:0] ea;
        clear_obs();
        run_burst(12'd100, 2, 2, 5);
        checks++;
        if (stalls != 0 || unstable != 0 || wr_in_resp != 0 || obs_data.size() != 3) begin
            errors++; $display("FAIL backpressure_hold: got stalls=%0d unstable=%0d wr_in_resp=%0d beats=%0d want 0/0/0/3",
                               stalls, unstable, wr_in_resp, obs_data.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                ea = AW'(100 + k);
                checks++;
                if (obs_addr[k] !== ea || obs_data[k] !== memf(ea, sent_data[k]) || obs_last[k] !== (k == 2)) begin
                    errors++; $display("FAIL backpressure_beat%0d: got addr=%0d data=%h last=%b want %0d/%h/%b",
                                       k, obs_addr[k], obs_data[k], obs_last[k], ea, memf(ea, sent_data[k]), (k == 2));
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        int errs_before;
        cmd_valid = 1; cmd_addr = 12'h100; cmd_len = LW'(3);
        tick;
        cmd_valid = 0; wr_valid = 1; wr_data = 16'h1111;
        tick;                         // ISSUE beat 1
        wr_valid = 0; mem_ready = 1;
        tick;                         // RESP beat 1
        mem_ready = 0; rsp_ready = 1;
        tick;                         // LOAD beat 2
        rsp_ready = 0; wr_valid = 1; wr_data = 16'h2222;
        tick;                         // ISSUE beat 2
        wr_valid = 0;
        checks++;
        if (mem_addr !== 12'h101 || busy !== 1'b1) begin
            errors++; $display("FAIL midburst_beat2: got mem_addr=%h busy=%b want 101/1", mem_addr, busy);
        end
        tick;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, wr_ready, mem_addr, mem_data_in, rsp_valid, rsp_data, rsp_last, busy, err} !== '0) begin
            errors++; $display("FAIL midburst_async_reset: got maddr=%h mdin=%h rv=%b rd=%h busy=%b cmd_ready=%b want all 0",
                               mem_addr, mem_data_in, rsp_valid, rsp_data, busy, cmd_ready);
        end
        mem_ready = 1;
        tick;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midburst_in_reset: got rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
        end
        mem_ready = 0;
        rst_n = 1'b1;
        tick;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midburst_release: got cmd_ready=%b want 1", cmd_ready); end
        clear_obs();
        run_burst(12'h040, 1, 1, 1);
        errs_before = errors;
        checks++;
        if (stalls != 0 || obs_data.size() != 2) begin
            errors++; $display("FAIL midburst_fresh: got stalls=%0d beats=%0d want 0/2", stalls, obs_data.size());
        end else if (obs_addr[1] !== 12'h041 || obs_data[1] !== memf(12'h041, sent_data[1]) || obs_last[1] !== 1'b1
                     || obs_last[0] !== 1'b0 || obs_data[0] !== memf(12'h040, sent_data[0])) begin
            errors++; $display("FAIL midburst_fresh_data: got addr1=%h d0=%h d1=%h want 041/%h/%h",
                               obs_addr[1], obs_data[0], obs_data[1], memf(12'h040, sent_data[0]), memf(12'h041, sent_data[1]));
        end
        if (errors != errs_before) $display("  (fresh command after reset)");
    endtask

    task automatic test_random;
        logic [AW-1:0] a, ea;
        logic [DW-1:0] ed;
        int len;
        for (int n = 0; n < 12; n++) begin
            a = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(DEPTH - 4, DEPTH - 1)) : AW'($urandom_range(0, DEPTH - 1));
            len = $urandom_range(0, 5);
            clear_obs();
            run_burst(a, len, $urandom_range(0, 3), $urandom_range(0, 3));
            checks++;
            if (stalls != 0 || unstable != 0 || obs_data.size() != len + 1) begin
                errors++; $display("FAIL random%0d_shape: got stalls=%0d unstable=%0d beats=%0d want 0/0/%0d",
                                   n, stalls, unstable, obs_data.size(), len + 1);
            end else begin
                for (int k = 0; k <= len; k++) begin
                    ea = AW'((int'(a) + k) % DEPTH);
                    ed = memf(ea, sent_data[k]);
                    checks++;
                    if (obs_addr[k] !== ea || obs_data[k] !== ed || obs_last[k] !== (k == len)) begin
                        errors++; $display("FAIL random%0d_beat%0d: got addr=%0d data=%h last=%b want %0d/%h/%b",
                                           n, k, obs_addr[k], obs_data[k], obs_last[k], ea, ed, (k == len));
                    end
                end
            end
        end
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        cmd_valid = 1; cmd_addr = 12'd5; cmd_len = LW'(3);
        tick;
        cmd_valid = 0; wr_valid = 1; wr_data = 16'hBEEF;
        tick;                         // ISSUE entered, mem_ready stuck low
        wr_valid = 0; mem_ready = 0;
        n = 0;
        while (err !== 1'b1 && n < 20) begin tick; n++; end
        checks++;
        if (n != TMO || rsp_valid !== 1'b1 || rsp_data !== '0 || rsp_last !== 1'b1) begin
            errors++; $display("FAIL timeout_resp: got cycles=%0d rsp_valid=%b data=%h last=%b want %0d/1/0000/1",
                               n, rsp_valid, rsp_data, rsp_last, TMO);
        end
        rsp_ready = 1;
        tick;
        rsp_ready = 0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: got err=%b busy=%b cmd_ready=%b rsp_valid=%b want 0/0/1/0",
                               err, busy, cmd_ready, rsp_valid);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_bad_addr();
        test_wrap();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
